mem_read_arbiter: RTL and testbench

Shares the single input-memory read port (req/ack/add/dataValid handshake) among NUM_REQ user-side requesters, e.g. the D-column loader, the X-vector loader and per-core OMP fetch engines. It arbitrates round-robin, forwards one address at a time to the memory interface, and tracks accepted reads in an ordered tag FIFO so each returning word is routed back to the requester that issued it. It sits between the user circuit's read clients and the memory interface's input-memory read port.

---
 rtl/mem_read_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_read_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing the input-memory read port among NUM_REQ requesters.
// An in-order tag FIFO remembers who issued each accepted read so returns are routed back.
module mem_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 17,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 reqReadReq,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      reqReadAdd,
  output logic [NUM_REQ-1:0]                 reqReadAck,
  output logic [NUM_REQ-1:0]                 reqReadDataValid,
  output logic [DATA_WIDTH-1:0]              reqReadData,
  output logic                               inputMemoryReadReq,
  input  logic                               inputMemoryReadAck,
  output logic [ADDR_WIDTH-1:0]              inputMemoryReadAdd,
  input  logic                               inputMemoryReadDataValid,
  input  logic [DATA_WIDTH-1:0]              inputMemoryReadData,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               errUnexpected
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [IW-1:0] pick;
  logic          pick_found;
  logic          launch;
  logic          push;
  logic          pop;
  logic          full;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] tag_mem [MAX_OUTSTANDING];

  assign full        = (count == CW'(MAX_OUTSTANDING));
  assign pop         = inputMemoryReadDataValid && (count != '0);
  assign outstanding = count;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick       = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && reqReadReq[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick       = IW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    push       = 1'b0;
    reqReadAck = '0;
    case (state)
      IDLE: begin
        if (pick_found && !full) begin
          launch     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (inputMemoryReadAck) begin
          push              = 1'b1;
          reqReadAck[grant] = 1'b1;
          state_next        = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant, address and request stay frozen for the whole ISSUE phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      grant              <= '0;
      inputMemoryReadAdd <= '0;
      inputMemoryReadReq <= 1'b0;
    end else begin
      state <= state_next;
      if (launch) begin
        grant              <= pick;
        inputMemoryReadAdd <= reqReadAdd[pick*ADDR_WIDTH +: ADDR_WIDTH];
        inputMemoryReadReq <= 1'b1;
        rr_ptr             <= (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
      end else if (push) begin
        inputMemoryReadReq <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  // A return with nothing outstanding means a tag was lost (e.g. reset mid-flight).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqReadDataValid <= '0;
      reqReadData      <= '0;
      errUnexpected    <= 1'b0;
    end else begin
      reqReadDataValid <= '0;
      if (pop) begin
        reqReadDataValid[tag_mem[rd_ptr]] <= 1'b1;
        reqReadData                       <= inputMemoryReadData;
      end
      if (inputMemoryReadDataValid && (count == '0)) errUnexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios and a randomized run, compared every
// cycle against a transaction-level model (pending request, tag queue, per-requester scoreboards).
module tb_mem_read_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 17;
  localparam int DW   = 32;
  localparam int MAXO = 8;
  localparam int OW   = $clog2(MAXO) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NR-1:0]    req_in = '0;
  logic [NR*AW-1:0] add_in = '0;
  logic             ack_in = 1'b0;
  logic             dv_in = 1'b0;
  logic [DW-1:0]    data_in = '0;

  logic [NR-1:0]    reqReadAck;
  logic [NR-1:0]    reqReadDataValid;
  logic [DW-1:0]    reqReadData;
  logic             inputMemoryReadReq;
  logic [AW-1:0]    inputMemoryReadAdd;
  logic [OW-1:0]    outstanding;
  logic             errUnexpected;

  mem_read_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reqReadReq(req_in),
    .reqReadAdd(add_in),
    .reqReadAck(reqReadAck),
    .reqReadDataValid(reqReadDataValid),
    .reqReadData(reqReadData),
    .inputMemoryReadReq(inputMemoryReadReq),
    .inputMemoryReadAck(ack_in),
    .inputMemoryReadAdd(inputMemoryReadAdd),
    .inputMemoryReadDataValid(dv_in),
    .inputMemoryReadData(data_in),
    .outstanding(outstanding),
    .errUnexpected(errUnexpected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  bit            m_busy;
  int            m_grant;
  logic [AW-1:0] m_addr;
  int            m_rr;
  int            m_tags[$];
  logic [NR-1:0] m_dv;
  logic [DW-1:0] m_dout;
  bit            m_err;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } mem_t;
  mem_t          memq[$];
  logic [AW-1:0] rq [NR][$];

  // Stimulus knobs
  int            left [NR];
  int            req_pct = 100;
  int            ack_pct = 100;
  int            ret_pct = 100;
  int            ret_left = 0;
  int            mem_lat = 1;
  bit            e2e = 1'b1;
  logic [DW-1:0] mask = '0;
  int            dut_acks [NR];
  int            dut_ack_total = 0;
  int            dv_count [NR];

  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
    return DW'(a) ^ mask;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_busy = 1'b0;
    m_grant = 0;
    m_addr = '0;
    m_rr = 0;
    m_tags.delete();
    m_dv = '0;
    m_dout = '0;
    m_err = 1'b0;
    memq.delete();
    dut_ack_total = 0;
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      dut_acks[i] = 0;
      dv_count[i] = 0;
      left[i] = 0;
    end
  endtask

  task automatic resetDut();
    reset = 1'b0;
    req_in = '0;
    ack_in = 1'b0;
    dv_in = 1'b0;
    #1;
    chk("rstMemReq", inputMemoryReadReq, 1'b0);
    chk("rstMemAdd", inputMemoryReadAdd, '0);
    chk("rstAck", reqReadAck, '0);
    chk("rstDv", reqReadDataValid, '0);
    chk("rstData", reqReadData, '0);
    chk("rstOut", outstanding, '0);
    chk("rstErr", errUnexpected, 1'b0);
    resetModel();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Observation point, mid-cycle: model expectations for registered and combinational outputs.
  task automatic settle();
    logic [DW-1:0] exp;
    #4;
    chk("memReq", inputMemoryReadReq, m_busy);
    if (m_busy) chk("memAdd", inputMemoryReadAdd, m_addr);
    chk("ack", reqReadAck, (m_busy && ack_in) ? (64'd1 << m_grant) : 64'd0);
    chk("dataValid", reqReadDataValid, m_dv);
    chk("data", reqReadData, m_dout);
    chk("outstanding", outstanding, m_tags.size());
    chk("errUnexpected", errUnexpected, m_err);
    for (int i = 0; i < NR; i++) begin
      if (reqReadAck[i]) begin
        dut_acks[i]++;
        dut_ack_total++;
      end
      if (reqReadDataValid[i]) begin
        dv_count[i]++;
        exp = 'x;
        if (rq[i].size() > 0) exp = mkdata(rq[i].pop_front());
        if (e2e) chk("e2eData", reqReadData, exp);
      end
    end
  endtask

  // Apply the effect of the clock edge just taken, using this cycle's inputs.
  task automatic clockEdge();
    int pre;
    bit found;
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    pre = m_tags.size();
    m_dv = '0;
    if (dv_in) begin
      if (pre > 0) begin
        m_dv[m_tags.pop_front()] = 1'b1;
        m_dout = data_in;
      end else begin
        m_err = 1'b1;
      end
    end
    if (m_busy) begin
      if (ack_in) begin
        m_tags.push_back(m_grant);
        memq.push_back('{addr: m_addr, due: cyc + ((mem_lat < 0) ? int'($urandom_range(1, 20)) : mem_lat)});
        rq[m_grant].push_back(m_addr);
        req_in[m_grant] = 1'b0;
        m_busy = 1'b0;
      end
    end else if (pre < MAXO) begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (!found && req_in[idx]) begin
          found = 1'b1;
          m_busy = 1'b1;
          m_grant = idx;
          m_addr = add_in[idx*AW +: AW];
          m_rr = (idx + 1) % NR;
        end
      end
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NR; i++) begin
      if (!req_in[i] && left[i] > 0 && $urandom_range(0, 99) < req_pct) begin
        req_in[i] = 1'b1;
        add_in[i*AW +: AW] = AW'($urandom);
        left[i]--;
      end
    end
    ack_in = m_busy && ($urandom_range(0, 99) < ack_pct);
    dv_in = 1'b0;
    if (memq.size() > 0 && ret_left > 0 && memq[0].due <= cyc && $urandom_range(0, 99) < ret_pct) begin
      dv_in = 1'b1;
      data_in = mkdata(memq[0].addr);
      void'(memq.pop_front());
      ret_left--;
    end
  endtask

  task automatic step();
    settle();
    clockEdge();
  endtask

  task automatic autoStep();
    applyStimulus();
    step();
  endtask

  initial begin
    bit got;
    int ord;
    resetModel();

    // Single read from requester 0: ack three cycles in, data five cycles after ack
    resetDut();
    e2e = 1'b0;
    req_in = 4'b0001;
    add_in[0 +: AW] = 17'h00010;
    step();
    for (int c = 0; c < 2; c++) step();
    ack_in = 1'b1;
    settle();
    chk("t1Ack", reqReadAck, 4'b0001);
    chk("t1Add", inputMemoryReadAdd, 17'h00010);
    clockEdge();
    ack_in = 1'b0;
    settle();
    chk("t1Out1", outstanding, 1);
    clockEdge();
    for (int c = 0; c < 3; c++) step();
    dv_in = 1'b1;
    data_in = 32'hDEADBEEF;
    step();
    dv_in = 1'b0;
    settle();
    chk("t1Dv", reqReadDataValid, 4'b0001);
    chk("t1Data", reqReadData, 32'hDEADBEEF);
    chk("t1Out0", outstanding, 0);
    clockEdge();

    // All requesters requesting continuously, immediate ack: rotation 0,1,2,3,...
    resetDut();
    for (int i = 0; i < NR; i++) add_in[i*AW +: AW] = AW'(17'h100 + i);
    ord = 0;
    for (int c = 0; c < 60 && ord < 8; c++) begin
      req_in = '1;
      ack_in = m_busy;
      settle();
      if (reqReadAck != '0) begin
        chk("t2Order", reqReadAck, 64'd1 << (ord % NR));
        chk("t2Addr", inputMemoryReadAdd, AW'(17'h100 + (ord % NR)));
        ord++;
      end
      clockEdge();
    end
    for (int i = 0; i < NR; i++) chk("t2AckCount", dut_acks[i], 2);

    // Requesters 1 and 3, three reads each, returns 10 cycles late with data = address
    resetDut();
    e2e = 1'b1;
    mask = '0;
    mem_lat = 10;
    ack_pct = 100;
    ret_pct = 100;
    req_pct = 100;
    ret_left = 100;
    left[1] = 3;
    left[3] = 3;
    for (int c = 0; c < 300 && !(dv_count[1] == 3 && dv_count[3] == 3); c++) autoStep();
    chk("t3DvCount1", dv_count[1], 3);
    chk("t3DvCount3", dv_count[3], 3);
    chk("t3Dv0", dv_count[0], 0);

    // Nine requests with no returns: FIFO fills at eight, one return lets the ninth go
    resetDut();
    mask = 32'h5A5A0000;
    mem_lat = 1;
    ret_left = 0;
    left[0] = 3; left[1] = 2; left[2] = 2; left[3] = 2;
    for (int c = 0; c < 40; c++) autoStep();
    settle();
    chk("t4Acks8", dut_ack_total, 8);
    chk("t4OutFull", outstanding, 8);
    chk("t4MemReqLow", inputMemoryReadReq, 1'b0);
    clockEdge();
    ret_left = 1;
    for (int c = 0; c < 10; c++) autoStep();
    chk("t4Acks9", dut_ack_total, 9);

    // Return with nothing outstanding, then reset with two reads in flight
    resetDut();
    dv_in = 1'b1;
    data_in = 32'h12345678;
    step();
    dv_in = 1'b0;
    settle();
    chk("t5Err", errUnexpected, 1'b1);
    chk("t5NoDv", reqReadDataValid, '0);
    clockEdge();
    ret_left = 0;
    ack_pct = 100;
    left[0] = 1;
    left[1] = 1;
    for (int c = 0; c < 20 && dut_ack_total < 2; c++) autoStep();
    left[2] = 1;
    ack_pct = 0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      applyStimulus();
      settle();
      if (m_busy && m_tags.size() == 2) got = 1'b1;
      else clockEdge();
    end
    chk("t5PreOut", outstanding, 2);
    chk("t5PreIssue", inputMemoryReadReq, 1'b1);
    resetDut();
    dv_in = 1'b1;
    data_in = 32'hCAFE0001;
    step();
    data_in = 32'hCAFE0002;
    step();
    dv_in = 1'b0;
    settle();
    chk("t5ErrLate", errUnexpected, 1'b1);
    chk("t5LateNoDv", reqReadDataValid, '0);
    clockEdge();

    // Randomized traffic with random ack delay and return latency, then drain
    resetDut();
    e2e = 1'b1;
    mask = 32'hA5C30000;
    mem_lat = -1;
    req_pct = 40;
    ack_pct = 60;
    ret_pct = 70;
    ret_left = 1000000;
    for (int i = 0; i < NR; i++) left[i] = 1000;
    for (int c = 0; c < 600; c++) autoStep();
    for (int i = 0; i < NR; i++) left[i] = 0;
    for (int c = 0; c < 200 && (m_busy || memq.size() > 0); c++) autoStep();
    for (int c = 0; c < 3; c++) autoStep();
    chk("drainOut", outstanding, 0);
    chk("drainErr", errUnexpected, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
